// File: rtl/ahb3lite_pkg.sv
// Shared AHB3-Lite encodings and types used by the interconnect blocks.
package ahb3lite_pkg;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    typedef enum logic [1:0] {AGE_IDLE, AGE_WAIT, AGE_BOOST} ahb3lite_age_state_t;
endpackage

// File: rtl/ahb3lite_interconnect_age_counter.sv
// Per-master starvation tracker: counts consecutive ungranted request cycles
// and holds a boost until the master is served or withdraws.
module ahb3lite_interconnect_age_counter
    import ahb3lite_pkg::*;
#(
    parameter  int AGE_LIMIT = 16,
    localparam int AGE_BITS  = $clog2(AGE_LIMIT)
) (
    input  logic HRESETn,
    input  logic HCLK,
    input  logic req,
    input  logic granted,
    input  logic hready,
    input  logic en,
    output logic boosted,
    output logic enter_boost
);
    ahb3lite_age_state_t state_q, state_d;
    logic [AGE_BITS-1:0] cnt_q, cnt_d;
    logic waiting, served;

    assign waiting = req & ~granted;
    assign served  = granted & hready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        enter_boost = 1'b0;
        if (!en) begin
            state_d = AGE_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                AGE_IDLE: begin
                    cnt_d = '0;
                    if (waiting) begin
                        state_d = AGE_WAIT;
                        cnt_d   = AGE_BITS'(1);
                    end
                end
                AGE_WAIT: begin
                    // served takes priority over reaching the limit
                    if (!req || served) begin
                        state_d = AGE_IDLE;
                        cnt_d   = '0;
                    end else if (waiting && cnt_q == AGE_BITS'(AGE_LIMIT - 1)) begin
                        state_d     = AGE_BOOST;
                        enter_boost = 1'b1;
                    end else if (waiting) begin
                        cnt_d = cnt_q + AGE_BITS'(1);
                    end
                end
                AGE_BOOST: begin
                    if (!req || served) begin
                        state_d = AGE_IDLE;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = AGE_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= AGE_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign boosted = (state_q == AGE_BOOST);
endmodule

// File: rtl/ahb3lite_interconnect_priority_aging.sv
// Slave-port starvation guard: raises long-waiting masters to top priority
// and counts how often that happens.
module ahb3lite_interconnect_priority_aging
    import ahb3lite_pkg::*;
#(
    parameter  int MASTERS     = 3,
    parameter  int AGE_LIMIT   = 16,
    localparam int MASTER_BITS = (MASTERS == 1) ? 1 : $clog2(MASTERS)
) (
    input  logic                                 HRESETn,
    input  logic                                 HCLK,
    input  logic                                 cfg_age_en,
    input  logic [MASTERS-1:0][MASTER_BITS-1:0] cfg_priority,
    input  logic [MASTERS-1:0]                   mstHSEL,
    input  logic [MASTERS-1:0][1:0]              mstHTRANS,
    input  logic [MASTERS-1:0]                   granted_master,
    input  logic                                 slv_HREADY,
    output logic [MASTERS-1:0][MASTER_BITS-1:0] mstpriority,
    output logic [MASTERS-1:0]                   starved,
    output logic [15:0]                          boost_events
);
    localparam int CW = $clog2(MASTERS + 1);

    logic [MASTERS-1:0] req, boosted, enter_boost;
    logic [CW-1:0]      pop;
    logic [16:0]        sum;
    logic [15:0]        boost_events_q, boost_events_d;

    for (genvar n = 0; n < MASTERS; n++) begin : g_age
        assign req[n] = mstHSEL[n] &
                        ((mstHTRANS[n] == HTRANS_NONSEQ) | (mstHTRANS[n] == HTRANS_SEQ));

        ahb3lite_interconnect_age_counter #(.AGE_LIMIT(AGE_LIMIT)) u_age (
            .HRESETn    (HRESETn),
            .HCLK       (HCLK),
            .req        (req[n]),
            .granted    (granted_master[n]),
            .hready     (slv_HREADY),
            .en         (cfg_age_en),
            .boosted    (boosted[n]),
            .enter_boost(enter_boost[n])
        );

        // Driven only from registered state and cfg; no request-to-priority path.
        assign mstpriority[n] = (boosted[n] & cfg_age_en) ? {MASTER_BITS{1'b1}} : cfg_priority[n];
    end

    assign starved = boosted;

    always_comb begin
        pop = '0;
        for (int i = 0; i < MASTERS; i++) pop = pop + CW'(enter_boost[i]);
        sum            = {1'b0, boost_events_q} + 17'(pop);
        boost_events_d = sum[16] ? 16'hFFFF : sum[15:0];
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) boost_events_q <= '0;
        else          boost_events_q <= boost_events_d;
    end

    assign boost_events = boost_events_q;
endmodule

// File: tb/tb_ahb3lite_interconnect_priority_aging.sv
// Bench for the priority-aging guard: directed scenarios, a random phase
// against a run-length model, and a saturation run on a wide, short-limit instance.
module tb_ahb3lite_interconnect_priority_aging;
    import ahb3lite_pkg::*;

    localparam int M  = 3;
    localparam int AL = 4;

    logic            HRESETn;
    logic            HCLK = 1'b0;
    logic            cfg_age_en;
    logic [M-1:0][1:0] cfg_priority;
    logic [M-1:0]    mstHSEL;
    logic [M-1:0][1:0] mstHTRANS;
    logic [M-1:0]    granted_master;
    logic            slv_HREADY;
    logic [M-1:0][1:0] mstpriority;
    logic [M-1:0]    starved;
    logic [15:0]     boost_events;

    logic [7:0][2:0] s_cfg_priority;
    logic [7:0]      s_hsel, s_gnt;
    logic [7:0][1:0] s_htrans;
    logic [7:0][2:0] s_prio;
    logic [7:0]      s_starved;
    logic [15:0]     s_events;

    int n_assert = 0;
    int n_fail   = 0;

    int run [M];
    bit mb  [M];
    int mev;

    always #5 HCLK = ~HCLK;

    ahb3lite_interconnect_priority_aging #(.MASTERS(M), .AGE_LIMIT(AL)) dut (
        .HRESETn(HRESETn), .HCLK(HCLK), .cfg_age_en(cfg_age_en), .cfg_priority(cfg_priority),
        .mstHSEL(mstHSEL), .mstHTRANS(mstHTRANS), .granted_master(granted_master),
        .slv_HREADY(slv_HREADY), .mstpriority(mstpriority), .starved(starved),
        .boost_events(boost_events)
    );

    ahb3lite_interconnect_priority_aging #(.MASTERS(8), .AGE_LIMIT(2)) dut_sat (
        .HRESETn(HRESETn), .HCLK(HCLK), .cfg_age_en(1'b1), .cfg_priority(s_cfg_priority),
        .mstHSEL(s_hsel), .mstHTRANS(s_htrans), .granted_master(s_gnt),
        .slv_HREADY(1'b1), .mstpriority(s_prio), .starved(s_starved),
        .boost_events(s_events)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < M; n++) begin run[n] = 0; mb[n] = 0; end
        mev = 0;
    endtask

    // A master boosts after AL consecutive ungranted request edges; any drop,
    // service or disable clears the run; granted-stalled edges freeze it.
    task automatic model_edge();
        for (int n = 0; n < M; n++) begin
            bit rq, srv, wt;
            rq  = mstHSEL[n] && mstHTRANS[n][1];
            srv = granted_master[n] && slv_HREADY;
            wt  = rq && !granted_master[n];
            if (!cfg_age_en || !rq || srv) begin
                run[n] = 0; mb[n] = 0;
            end else if (!mb[n] && wt) begin
                run[n]++;
                if (run[n] == AL) begin
                    mb[n] = 1;
                    if (mev < 65535) mev++;
                end
            end
        end
    endtask

    function automatic logic [M-1:0][1:0] exp_prio();
        logic [M-1:0][1:0] e;
        for (int n = 0; n < M; n++) e[n] = (mb[n] && cfg_age_en) ? 2'b11 : cfg_priority[n];
        return e;
    endfunction

    function automatic logic [M-1:0] exp_starved();
        logic [M-1:0] e;
        for (int n = 0; n < M; n++) e[n] = mb[n];
        return e;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, "_starved"}, 32'(starved), 32'(exp_starved()));
        chk({tag, "_prio"}, 32'(mstpriority), 32'(exp_prio()));
        chk({tag, "_events"}, 32'(boost_events), 32'(mev));
    endtask

    task automatic drive(input logic en, input logic [M-1:0] hsel, input logic [M-1:0][1:0] tr,
                         input logic [M-1:0] gnt, input logic rdy);
        cfg_age_en = en; mstHSEL = hsel; mstHTRANS = tr; granted_master = gnt; slv_HREADY = rdy;
    endtask

    task automatic step(input string tag);
        #1 chk({tag, "_comb_prio"}, 32'(mstpriority), 32'(exp_prio()));
        @(posedge HCLK);
        model_edge();
        #1 check_all(tag);
    endtask

    initial begin
        logic [M-1:0][1:0] tr;
        int base;
        HRESETn = 1'b0;
        cfg_priority = '0;
        cfg_priority[0] = 2'd2;
        drive(1'b1, '0, '0, '0, 1'b1);
        s_cfg_priority = '0; s_hsel = '0; s_htrans = '0; s_gnt = '0;
        model_reset();
        #2 check_all("reset");
        #10 HRESETn = 1'b1;

        // Starvation: master0 owns the slave, master1 waits
        tr = '0; tr[0] = HTRANS_NONSEQ; tr[1] = HTRANS_NONSEQ;
        drive(1'b1, 3'b011, tr, 3'b001, 1'b1);
        repeat (3) step("starve");
        chk("pre_boost", 32'(starved[1]), 32'd0);
        step("starve");
        chk("boost_starved1", 32'(starved[1]), 32'd1);
        chk("boost_prio1", 32'(mstpriority[1]), 32'd3);
        chk("boost_events1", 32'(boost_events), 32'd1);

        // Release: granted with two stall cycles
        drive(1'b1, 3'b011, tr, 3'b010, 1'b0);
        repeat (2) step("stall");
        chk("stall_held", 32'(starved[1]), 32'd1);
        slv_HREADY = 1'b1;
        step("release");
        chk("release_starved", 32'(starved[1]), 32'd0);
        chk("release_prio", 32'(mstpriority[1]), 32'd0);

        // Single-cycle request drop restarts the count
        drive(1'b1, 3'b011, tr, 3'b001, 1'b1);
        repeat (3) step("drop_pre");
        mstHTRANS[1] = HTRANS_IDLE;
        step("drop");
        mstHTRANS[1] = HTRANS_SEQ;
        repeat (3) step("drop_post");
        chk("drop_no_boost", 32'(starved[1]), 32'd0);
        step("drop_post");
        chk("drop_boost", 32'(starved[1]), 32'd1);

        // Disable while boosted: priority reverts combinationally
        cfg_age_en = 1'b0;
        #1 chk("dis_comb_prio", 32'(mstpriority[1]), 32'd0);
        step("dis");
        chk("dis_idle", 32'(starved), 32'd0);
        base = mev;
        repeat (100) step("dis_starve");
        chk("dis_no_events", 32'(boost_events), 32'(base));

        // Two masters boosting on the same edge
        tr[2] = HTRANS_NONSEQ;
        drive(1'b1, 3'b111, tr, 3'b001, 1'b1);
        base = mev;
        repeat (4) step("dual");
        chk("dual_events", 32'(boost_events), 32'(base + 2));
        chk("dual_starved", 32'(starved), 32'b110);

        // Random phase with sticky grants to give waits a chance to age
        for (int i = 0; i < 400; i++) begin
            int r;
            cfg_age_en = ($urandom_range(0, 15) != 0);
            for (int n = 0; n < M; n++) begin
                mstHSEL[n]   = ($urandom_range(0, 7) != 0);
                mstHTRANS[n] = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 1))
                                                           : 2'($urandom_range(2, 3));
            end
            if ($urandom_range(0, 3) == 0) begin
                r = $urandom_range(0, 3);
                granted_master = (r == 3) ? 3'b000 : 3'(1 << r);
            end
            slv_HREADY = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 31) == 0) cfg_priority = 6'($urandom);
            step("rand");
        end

        // Reset mid-operation
        cfg_priority = 6'b00_01_10;
        drive(1'b1, 3'b111, tr, 3'b001, 1'b1);
        repeat (6) step("pre_rst");
        #3 HRESETn = 1'b0;
        model_reset();
        #1 check_all("midrst");
        chk("midrst_starved", 32'(starved), 32'd0);
        chk("midrst_events", 32'(boost_events), 32'd0);
        chk("midrst_prio", 32'(mstpriority), 32'(cfg_priority));
        #3 HRESETn = 1'b1;
        drive(1'b1, '0, '0, '0, 1'b1);

        // Saturation: 8 masters, limit 2 -> 8 boosts every 3 cycles
        @(posedge HCLK); #1;
        chk("sat_start", 32'(s_events), 32'd0);
        s_hsel = 8'hFF;
        for (int r = 0; r < 8193; r++) begin
            s_htrans = {8{HTRANS_NONSEQ}};
            repeat (2) @(posedge HCLK);
            #1;
            if (r == 0 || r >= 8190) begin
                chk("sat_starved", 32'(s_starved), 32'hFF);
                chk("sat_events", 32'(s_events), (8 * (r + 1) > 65535) ? 32'hFFFF : 32'(8 * (r + 1)));
            end
            s_htrans = '0;
            @(posedge HCLK);
            #1;
        end
        chk("sat_hold", 32'(s_events), 32'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
